weight_fetch_seq: RTL

WEIGHT_FETCH_SEQ -- requirements
Module: weight_fetch_seq

---
 rtl/weight_fetch_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/weight_fetch_seq.sv
// Weight fetch sequencer: streams a len-word window of a weight bank to the PE array.
// Latency: first w_valid two edges after the edge that accepts start; 1 word/cycle with w_ready high.
// Backpressure: reads stop while the 2-entry skid buffer plus the in-flight read would overflow; nothing dropped.
//
// Ports:
//   clk, rst           single rising-edge clock, asynchronous active-high reset
//   start              burst request pulse, sampled only in IDLE
//   base_addr, len     burst window, captured on accepted start (len = 0 gives an immediate done)
//   busy, done         burst in progress / one-cycle completion pulse
//   mem_csen, mem_rdena, mem_addr, mem_data
//                      weight bank read port, read data returns one cycle after issue
//   w_valid, w_ready, w_data, w_last
//                      valid/ready weight stream, w_last on the final word of the burst
//   rep_cnt            (WFETCH_REPEAT_EN only) window is replayed rep_cnt+1 times
//
// Optional feature macro: WFETCH_REPEAT_EN.
module weight_fetch_seq #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef WFETCH_REPEAT_EN
    input  logic [3:0]            rep_cnt,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_csen,
    output logic                  mem_rdena,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] nxt_addr_q, nxt_addr_d;   // address of the next read to issue
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;   // address of the most recent read
    logic [ADDR_WIDTH:0]   rem_q, rem_d;             // reads left in the current pass
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    // 2-entry skid buffer holding {last, data}
    logic [DATA_WIDTH-1:0] buf_dat_q [2];
    logic [DATA_WIDTH-1:0] buf_dat_d [2];
    logic [1:0]            buf_last_q, buf_last_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

`ifdef WFETCH_REPEAT_EN
    logic [3:0]            rep_q, rep_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
`endif

    logic       push;
    logic       pop;
    logic       head_last;
    logic [2:0] slots_used;
    logic       issue;
    logic       final_pass;
    logic       last_issue;

    assign push      = inflight_q;
    assign w_valid   = (cnt_q != 2'd0);
    assign pop       = w_valid & w_ready;
    assign head_last = buf_last_q[rd_ptr_q];

    // A word leaving the buffer this cycle frees its slot for the read issued now,
    // which keeps one word per cycle flowing when w_ready stays high.
    assign slots_used = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign issue      = (state_q == FETCH) && (slots_used < (3'd2 + {2'b00, pop}));

`ifdef WFETCH_REPEAT_EN
    assign final_pass = (rep_q == 4'd0);
`else
    assign final_pass = 1'b1;
`endif
    assign last_issue = issue && (rem_q == REM_ONE) && final_pass;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // Sequencing
    always_comb begin
        state_d         = state_q;
        nxt_addr_d      = nxt_addr_q;
        mem_addr_d      = mem_addr_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_last_d = last_issue;
        done_d          = 1'b0;
`ifdef WFETCH_REPEAT_EN
        rep_d           = rep_q;
        base_d          = base_q;
        len_d           = len_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        nxt_addr_d = base_addr;
                        rem_d      = len;
`ifdef WFETCH_REPEAT_EN
                        rep_d      = rep_cnt;
                        base_d     = base_addr;
                        len_d      = len;
`endif
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    mem_addr_d = nxt_addr_q;
                    nxt_addr_d = addr_inc(nxt_addr_q);
                    if (rem_q == REM_ONE) begin
                        if (final_pass) begin
                            state_d = DRAIN;
                        end else begin
`ifdef WFETCH_REPEAT_EN
                            rep_d      = rep_q - 4'd1;
                            rem_d      = len_q;
                            nxt_addr_d = base_q;
`endif
                        end
                    end else begin
                        rem_d = rem_q - REM_ONE;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer bookkeeping
    always_comb begin
        buf_dat_d  = buf_dat_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (push) begin
            buf_dat_d[wr_ptr_q]  = mem_data;
            buf_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Clearing inflight_q on reset also drops whatever mem_data returns
    // in the first cycle after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            nxt_addr_q      <= '0;
            mem_addr_q      <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            buf_dat_q       <= '{default: '0};
            buf_last_q      <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            cnt_q           <= '0;
`ifdef WFETCH_REPEAT_EN
            rep_q           <= '0;
            base_q          <= '0;
            len_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            nxt_addr_q      <= nxt_addr_d;
            mem_addr_q      <= mem_addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            buf_dat_q       <= buf_dat_d;
            buf_last_q      <= buf_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
`ifdef WFETCH_REPEAT_EN
            rep_q           <= rep_d;
            base_q          <= base_d;
            len_q           <= len_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_csen  = issue;
    assign mem_rdena = issue;
    // The bank sees the new address only while a read is issued; otherwise it holds.
    assign mem_addr  = issue ? nxt_addr_q : mem_addr_q;
    assign w_data    = w_valid ? buf_dat_q[rd_ptr_q] : '0;
    assign w_last    = w_valid & head_last;

endmodule
